// File: rtl/traffic_pkg.sv
// traffic_pkg: state encodings shared by the sensor conditioning channels and
// the two-street Moore light controller.
// Build option: define SENSOR_STRETCH_EN to compile in the HOLD (stretch) state.
package traffic_pkg;

`ifdef SENSOR_STRETCH_EN
    localparam int STATE_W = 3;
`else
    localparam int STATE_W = 2;
`endif

    typedef enum logic [STATE_W-1:0] {
        IDLE      = STATE_W'(0),
        ARMING    = STATE_W'(1),
        ACTIVE    = STATE_W'(2),
`ifdef SENSOR_STRETCH_EN
        RELEASING = STATE_W'(3),
        HOLD      = STATE_W'(4)
`else
        RELEASING = STATE_W'(3)
`endif
    } state_e;

    // Occupancy level a channel reports while sitting in a given state.
    function automatic logic state_occupied(input state_e st);
        return (st != IDLE) && (st != ARMING);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: one car-detector channel. Two-flop synchroniser, debounce
// FSM with a shared run counter, and a registered occupancy output that is the
// decode of the next state.
// Build option: SENSOR_STRETCH_EN inserts HOLD after a debounced release.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam bit               DEB_ONE  = (DEB_CYCLES == 1);

`ifdef SENSOR_STRETCH_EN
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam state_e           REL_TARGET = HOLD;
`else
    localparam state_e           REL_TARGET = IDLE;
`endif
    localparam logic             REL_LEVEL  = state_occupied(REL_TARGET);

    logic             r_meta;
    logic             r_sync;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // Bring the asynchronous detector into the clock domain.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make r_sync take the old r_meta,
        // giving two real flop stages instead of one collapsed wire.
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // Debounce FSM: counter restarts on every state change, output follows next state.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_sync) begin
                        if (DEB_ONE) begin
                            r_state <= ACTIVE;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                        end else begin
                            r_state <= ARMING;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (!r_sync) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= ACTIVE;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!r_sync) begin
                        if (DEB_ONE) begin
                            r_state <= REL_TARGET;
                            r_cnt   <= '0;
                            r_level <= REL_LEVEL;
                        end else begin
                            r_state <= RELEASING;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                end
                RELEASING: begin
                    if (r_sync) begin
                        r_state <= ACTIVE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= REL_TARGET;
                        r_cnt   <= '0;
                        r_level <= REL_LEVEL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef SENSOR_STRETCH_EN
                HOLD: begin
                    if (r_sync) begin
                        r_state <= ACTIVE;
                        r_cnt   <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/traffic_sensor_filter.sv
// traffic_sensor_filter: conditions the raw street-A and street-B car detectors
// into clean TA/TB occupancy levels for the Moore light controller. The two
// channels are identical and fully independent.
// Build option: SENSOR_STRETCH_EN holds each output HOLD_CYCLES longer after release.
module traffic_sensor_filter
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sa_raw,
    input  logic sb_raw,
    output logic TA,
    output logic TB
);

    sensor_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_deb_a (
        .clk     (clk),
        .i_rst_n (reset),
        .i_raw   (sa_raw),
        .o_level (TA)
    );

    sensor_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_deb_b (
        .clk     (clk),
        .i_rst_n (reset),
        .i_raw   (sb_raw),
        .o_level (TB)
    );

endmodule

// File: tb/tb_traffic_sensor_filter.sv
// tb_traffic_sensor_filter: directed scenarios plus randomized detector traffic.
// Each issued cycle pushes the reference model's expected {TA,TB} into a queue;
// a monitor pops and compares one entry after every rising edge.
module tb_traffic_sensor_filter;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int CW   = 4;
`ifdef SENSOR_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif
    localparam int          RISE_EDGES = DEB + 2;
    localparam int          FALL_EDGES = DEB + 2 + (STRETCH ? HOLD : 0);
    localparam logic [31:0] WIN_MASK   = (32'd1 << DEB) - 32'd1;

    logic clk = 1'b0;
    logic reset;
    logic sa_raw;
    logic sb_raw;
    logic TA;
    logic TB;

    int    n_checks = 0;
    int    n_fail   = 0;
    string cur_phase = "reset";
    logic  cur_a = 1'b0;
    logic  cur_b = 1'b0;

    logic [1:0] exp_q[$];

    // Reference model per channel: two-edge sampling delay, window of recent
    // samples, current level and remaining stretch length.
    logic        m_p0[2];
    logic        m_p1[2];
    logic [31:0] m_win[2];
    logic        m_out[2];
    int          m_str[2];

    traffic_sensor_filter #(
        .DEB_CYCLES  (DEB),
        .CNT_W       (CW),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sa_raw (sa_raw),
        .sb_raw (sb_raw),
        .TA     (TA),
        .TB     (TB)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge with the given inputs.
    task automatic model_edge(input logic rst_n_v, input logic a, input logic b);
        logic raw;
        logic s;
        logic all1;
        logic all0;
        for (int ch = 0; ch < 2; ch++) begin
            raw = (ch == 0) ? a : b;
            if (!rst_n_v) begin
                m_p0[ch]  = 1'b0;
                m_p1[ch]  = 1'b0;
                m_win[ch] = '0;
                m_out[ch] = 1'b0;
                m_str[ch] = 0;
            end else begin
                s         = m_p1[ch];
                m_p1[ch]  = m_p0[ch];
                m_p0[ch]  = raw;
                m_win[ch] = {m_win[ch][30:0], s};
                all1      = (m_win[ch] & WIN_MASK) == WIN_MASK;
                all0      = (m_win[ch] & WIN_MASK) == '0;
                if (!m_out[ch]) begin
                    if (all1) m_out[ch] = 1'b1;
                end else if (m_str[ch] > 0) begin
                    if (s) begin
                        m_str[ch] = 0;
                    end else begin
                        m_str[ch]--;
                        if (m_str[ch] == 0) m_out[ch] = 1'b0;
                    end
                end else if (all0) begin
                    if (STRETCH) m_str[ch] = HOLD;
                    else         m_out[ch] = 1'b0;
                end
            end
        end
        exp_q.push_back({m_out[0], m_out[1]});
    endtask

    // Drive one cycle from a falling edge, through the rising edge, to the next falling edge.
    task automatic step(input logic rst_n_v, input logic a, input logic b);
        reset  = rst_n_v;
        sa_raw = a;
        sb_raw = b;
        cur_a  = a;
        cur_b  = b;
        model_edge(rst_n_v, a, b);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold sa_raw at 'a' and count edges until TA reaches 'target'.
    task automatic measure_a(input string name, input logic a, input logic target, input int exp_edges);
        int n;
        n = 0;
        cur_phase = name;
        do begin
            step(1'b1, a, cur_b);
            n++;
        end while (TA !== target && n < 60);
        check(name, n, exp_edges);
    endtask

    // Pulses starting together on both inputs; report first TA rise and any TB activity.
    task automatic pulses(input string name, input int len_a, input int len_b, input int steps,
                          output int first_a, output logic tb_seen);
        first_a = -1;
        tb_seen = 1'b0;
        cur_phase = name;
        for (int i = 1; i <= steps; i++) begin
            step(1'b1, (i <= len_a), (i <= len_b));
            if (TA === 1'b1 && first_a < 0) first_a = i;
            if (TB !== 1'b0) tb_seen = 1'b1;
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: one expected entry per rising edge, sampled just after it.
    initial begin
        logic [1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check({"scoreboard_", cur_phase}, {30'd0, TA, TB}, {30'd0, exp});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   first_a;
        logic tb_seen;
        logic seen_low;
        int   rem_a;
        int   rem_b;
        logic ra;
        logic rb;
        logic rs;

        reset  = 1'b0;
        sa_raw = 1'b1;
        sb_raw = 1'b1;
        @(negedge clk);

        // Reset held with both detectors active: outputs must stay low.
        cur_phase = "reset_hold";
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("reset_ta_tb", {30'd0, TA, TB}, 32'd0);

        measure_a("assert_after_reset", 1'b1, 1'b1, RISE_EDGES);
        check("tb_after_reset", {31'd0, TB}, 32'd1);
        measure_a("deassert_latency", 1'b0, 1'b0, FALL_EDGES);

        cur_b = 1'b0;
        settle(FALL_EDGES + 4);

        // Glitch shorter than the debounce window never reaches the output.
        pulses("glitch3", DEB - 1, 0, 30, first_a, tb_seen);
        check("glitch3_no_rise", first_a, -1);

        // A pulse of exactly the window length does.
        pulses("pulse4", DEB, 0, 30, first_a, tb_seen);
        check("pulse4_rise", first_a, RISE_EDGES);

        // Short low blip while occupied is filtered out.
        measure_a("rise_before_blip", 1'b1, 1'b1, RISE_EDGES);
        seen_low  = 1'b0;
        cur_phase = "blip2";
        for (int i = 1; i <= 14; i++) begin
            step(1'b1, !(i <= 2), 1'b0);
            if (TA !== 1'b1) seen_low = 1'b1;
        end
        check("blip2_no_drop", {31'd0, seen_low}, 32'd0);

        // Low for 8 cycles, then back: inside HOLD with stretch, a real release without.
        seen_low  = 1'b0;
        cur_phase = "hold_reraise";
        for (int i = 1; i <= 18; i++) begin
            step(1'b1, !(i <= 8), 1'b0);
            if (TA !== 1'b1) seen_low = 1'b1;
        end
        check("hold_reraise_drop", {31'd0, seen_low}, {31'd0, !STRETCH});
        if (TA !== 1'b1) measure_a("reraise_recover", 1'b1, 1'b1, RISE_EDGES - 2);
        check("ta_high_before_reset", {31'd0, TA}, 32'd1);

        // Reset in the middle of ACTIVE, then a full re-arm.
        cur_phase = "reset_mid";
        step(1'b0, 1'b1, 1'b0);
        check("reset_mid_ta", {31'd0, TA}, 32'd0);
        measure_a("rearm_after_reset", 1'b1, 1'b1, RISE_EDGES);

        settle(FALL_EDGES + 6);

        // Simultaneous edges with different pulse lengths on the two streets.
        pulses("independence", 5, 2, 30, first_a, tb_seen);
        check("indep_ta_rise", first_a, RISE_EDGES);
        check("indep_tb_quiet", {31'd0, tb_seen}, 32'd0);

        // Randomized traffic with random run lengths and rare resets.
        cur_phase = "random";
        ra = 1'b0;
        rb = 1'b0;
        rem_a = 1;
        rem_b = 1;
        for (int i = 0; i < 3000; i++) begin
            rem_a--;
            if (rem_a == 0) begin
                ra    = !ra;
                rem_a = $urandom_range(1, 2 * DEB + HOLD);
            end
            rem_b--;
            if (rem_b == 0) begin
                rb    = !rb;
                rem_b = $urandom_range(1, 2 * DEB + HOLD);
            end
            rs = ($urandom_range(0, 299) != 0);
            step(rs, ra, rb);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_filter.md
# traffic_sensor_filter

Upstream conditioning stage for the two-street traffic-light Moore controller. Takes the raw, asynchronous, bouncy car-detector inputs for street A and street B. Synchronises and debounces each one and drives clean `TA`/`TB` level signals straight into the controller's sensor inputs. Both channels are independent and identical.

## Interface
Parameters:
- `DEB_CYCLES`, 4: consecutive synchronised samples required to change an output level; legal range 1..2^CNT_W-1.
- `CNT_W`, 4: width of each channel's counter; must hold `max(DEB_CYCLES, HOLD_CYCLES)`.
- `HOLD_CYCLES`, 8: stretch length after release. Used only with `SENSOR_STRETCH_EN`.

Ports:
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `sa_raw`  in  1: raw street-A detector, asynchronous.
- `sb_raw`  in  1: raw street-B detector, asynchronous.
- `TA`  out  1: debounced street-A occupancy, registered.
- `TB`  out  1: debounced street-B occupancy, registered.

## Operation
- Per channel: 2-flop synchroniser produces `s`. A state register and a counter `cnt` (width CNT_W) act on `s`.
- States:
  - IDLE: out 0.
  - ARMING: out 0.
  - ACTIVE: out 1.
  - RELEASING: out 1.
  - HOLD: out 1; exists only with the macro.
- IDLE:
  - `s=1` goes to ARMING with cnt=1.
  - If DEB_CYCLES==1, `s=1` goes directly to ACTIVE instead.
  - `s=0` stays in IDLE.
- ARMING:
  - `s=1` and cnt==DEB_CYCLES-1 goes to ACTIVE.
  - `s=1` otherwise increments cnt.
  - `s=0` goes to IDLE with cnt=0.
- ACTIVE:
  - `s=0` goes to RELEASING with cnt=1.
  - If DEB_CYCLES==1, `s=0` goes directly to the release target instead.
- RELEASING:
  - `s=0` and cnt==DEB_CYCLES-1 goes to the release target.
  - `s=0` otherwise increments cnt.
  - `s=1` goes back to ACTIVE.
- Release target: IDLE without the macro, HOLD with cnt=0 with the macro.
- HOLD:
  - `s=1` goes to ACTIVE immediately.
  - Otherwise cnt increments.
  - cnt==HOLD_CYCLES-1 goes to IDLE.
- Output = registered decode of the next state. `TA`/`TB` therefore change on the same edge as the state.
- Counter never wraps. It is cleared on every state change and saturates by construction.
- Channels never interact. Simultaneous A/B edges are processed independently on the same cycle.

## Timing
- Reset: with `reset`=0 at a rising edge:
  - sync flops, state and cnt clear to 0 / IDLE.
  - `TA`=`TB`=0 after that edge.
  - Applies mid-operation from any state, including HOLD.
- Assert latency: raw held high from edge 0 gives output 1 after edge DEB_CYCLES+1. This is the (DEB_CYCLES+2)-th sampling edge; for DEB=4, output rises after edge 5.
- Deassert latency, no macro: same, DEB_CYCLES+2 edges after raw falls.
- With macro: deassert takes DEB_CYCLES+2+HOLD_CYCLES edges.
- A glitch shorter than DEB_CYCLES synchronised samples never changes the output.
- A pulse of exactly DEB_CYCLES samples does change it.
- First active clock edge after reset release: state machine samples sync flops that were cleared. No spurious output.

## Configuration
- Macro: `SENSOR_STRETCH_EN`.
- Defined: the HOLD state is compiled in. The output stays high HOLD_CYCLES extra cycles after a debounced release, bridging gaps between closely following cars. `s=1` during HOLD returns to ACTIVE with no output drop.
- Undefined:
  - HOLD logic and `HOLD_CYCLES` usage are removed.
  - RELEASING goes straight to IDLE.
  - State register shrinks to 2 bits.

## Structure
- Shared package `traffic_pkg` holds:
  - the channel state encodings: IDLE=0, ARMING=1, ACTIVE=2, RELEASING=3, HOLD=4;
  - the state-width constant.
- The Moore controller reuses this package for its own encodings.
- Sub-module `sensor_debounce`: one channel (synchroniser, FSM, counter, output flop). Top instantiates it twice: A→`TA`, B→`TB`.

## Test plan
All scenarios: DEB_CYCLES=4, HOLD_CYCLES=8, 10-unit clock.
- Reset: `reset`=0 for 2 edges with both raw inputs at 1 → `TA`=`TB`=0 throughout. After release, `TA` rises exactly 6 edges after the first sampling edge.
- Glitch rejection: `sa_raw` high for 3 cycles, then low → `TA` stays 0. A 4-cycle pulse → `TA`=1 after 6 edges.
- Release without macro: `sa_raw` steady high, then low → `TA` falls after 6 edges. A 2-cycle low blip while high → `TA` remains 1.
- Stretch with macro: `sa_raw` falls → `TA` falls after 14 edges. Re-raising `sa_raw` during HOLD → `TA` never drops.
- Independence: `sa_raw` and `sb_raw` toggled on the same cycle with different pulse lengths (5 and 2) → only `TA` asserts.
- Reset mid-ACTIVE: `reset`=0 while `TA`=1 → `TA`=0 after that edge; re-arm needs the full 6 edges.
